// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access unit between the multicycle core and a
// word-addressed memory port. Handles one byte/half/word(/double) access at a
// time, aligns the address, builds the store byte mask and lane-shifted data,
// and sign/zero-extends load results. Misaligned or illegal sizes are rejected
// without touching memory; an optional timeout bounds the wait for mem_resp.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_size      store flag, size 0=B 1=H 2=W 3=D (D only for XLEN=64)
//   req_unsigned          zero-extend load result
//   req_addr, req_wdata   byte address, right-justified store data
//   mem_address           aligned address (low offset bits zero)
//   mem_read, mem_write   strobes held for the whole access
//   mem_wmask, mem_wdata  byte-lane enables and lane-shifted store data
//   mem_rdata, mem_resp   memory read data and completion
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             extended load result (0 for stores / errors)
//   rsp_misaligned        request rejected (misaligned or illegal size)
//   rsp_timeout           access aborted by timeout
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [XLEN-1:0]   mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_misaligned,
  output logic              rsp_timeout
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_nxt;
  logic            we_q, we_nxt, uns_q, uns_nxt;
  logic [1:0]      size_q, size_nxt;
  logic [OW-1:0]   off_q, off_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt, cnt_inc;
  logic            ready_nxt, read_nxt, write_nxt, valid_nxt, mis_nxt, tmo_nxt;
  logic [XLEN-1:0] addr_nxt, wdata_nxt, rdata_nxt;
  logic [NB-1:0]   wmask_nxt;

  // request decode
  logic [OW-1:0]   req_off;
  logic            req_bad;
  logic [NB-1:0]   req_mask;
  logic [XLEN-1:0] req_shdata;

  assign req_off    = req_addr[OW-1:0];
  assign req_shdata = req_wdata << {req_off, 3'b000};

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'd1:    req_bad = req_addr[0];
      2'd2:    req_bad = |req_addr[1:0];
      2'd3:    req_bad = (XLEN == 32) || (|req_addr[2:0]);
      default: req_bad = 1'b0;
    endcase
  end

  // lanes [off, off + bytes) are written
  always_comb begin
    req_mask = '0;
    for (int i = 0; i < NB; i++)
      req_mask[i] = (32'(i) >= 32'(req_off)) &&
                    (32'(i) < 32'(req_off) + (32'd1 << req_size));
  end

  // load extract: shift lane down, keep 8<<size bits, extend from its MSB
  logic [XLEN-1:0] ld_sh, ld_mask, ld_ext;
  logic            ld_sgn;

  assign ld_sh = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_mask = '0;
    for (int i = 0; i < XLEN; i++)
      ld_mask[i] = (32'(i) < (32'd8 << size_q));
  end

  // MSB of the kept field is the one mask bit whose upper neighbour is clear
  assign ld_sgn = |(ld_sh & ld_mask & ~(ld_mask >> 1));
  assign ld_ext = (ld_sh & ld_mask) | ({XLEN{ld_sgn & ~uns_q}} & ~ld_mask);

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_nxt = state;
    we_nxt    = we_q;
    uns_nxt   = uns_q;
    size_nxt  = size_q;
    off_nxt   = off_q;
    cnt_nxt   = cnt_q;
    ready_nxt = req_ready;
    read_nxt  = mem_read;
    write_nxt = mem_write;
    valid_nxt = 1'b0;
    mis_nxt   = rsp_misaligned;
    tmo_nxt   = rsp_timeout;
    addr_nxt  = mem_address;
    wdata_nxt = mem_wdata;
    wmask_nxt = mem_wmask;
    rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_nxt    = req_we;
          uns_nxt   = req_unsigned;
          size_nxt  = req_size;
          off_nxt   = req_off;
          ready_nxt = 1'b0;
          if (req_bad) begin
            state_nxt = DONE;
            valid_nxt = 1'b1;
            mis_nxt   = 1'b1;
          end else begin
            state_nxt = ACCESS;
            cnt_nxt   = '0;
            addr_nxt  = {req_addr[XLEN-1:OW], {OW{1'b0}}};
            read_nxt  = ~req_we;
            write_nxt = req_we;
            if (req_we) begin
              wmask_nxt = req_mask;
              wdata_nxt = req_shdata;
            end
          end
        end
      end
      ACCESS: begin
        cnt_nxt = cnt_inc;
        if (mem_resp) begin
          state_nxt = DONE;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          valid_nxt = 1'b1;
          rdata_nxt = we_q ? '0 : ld_ext;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_inc == CW'(TIMEOUT_CYCLES))) begin
          state_nxt = DONE;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          valid_nxt = 1'b1;
          tmo_nxt   = 1'b1;
          rdata_nxt = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
        mis_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        rdata_nxt = '0;
        wmask_nxt = '0;
        wdata_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= 2'd0;
      off_q          <= '0;
      cnt_q          <= '0;
      req_ready      <= 1'b1;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_wmask      <= '0;
      mem_wdata      <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
      rsp_timeout    <= 1'b0;
    end else begin
      state          <= state_nxt;
      we_q           <= we_nxt;
      uns_q          <= uns_nxt;
      size_q         <= size_nxt;
      off_q          <= off_nxt;
      cnt_q          <= cnt_nxt;
      req_ready      <= ready_nxt;
      mem_read       <= read_nxt;
      mem_write      <= write_nxt;
      mem_address    <= addr_nxt;
      mem_wmask      <= wmask_nxt;
      mem_wdata      <= wdata_nxt;
      rsp_valid      <= valid_nxt;
      rsp_rdata      <= rdata_nxt;
      rsp_misaligned <= mis_nxt;
      rsp_timeout    <= tmo_nxt;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: an XLEN=32 instance with an 8-cycle timeout and an
// XLEN=64 instance without timeout. sel chooses which one receives requests.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid, req_we, req_unsigned, mem_resp;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, mem_rdata;

  logic        a32_ready, a32_read, a32_write, a32_valid, a32_mis, a32_tmo;
  logic [31:0] a32_addr, a32_wdata, a32_rdata;
  logic [3:0]  a32_wmask;
  logic        a64_ready, a64_read, a64_write, a64_valid, a64_mis, a64_tmo;
  logic [63:0] a64_addr, a64_wdata, a64_rdata;
  logic [7:0]  a64_wmask;

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a32_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .mem_address(a32_addr), .mem_read(a32_read), .mem_write(a32_write),
    .mem_wmask(a32_wmask), .mem_wdata(a32_wdata),
    .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp & ~sel),
    .rsp_valid(a32_valid), .rsp_rdata(a32_rdata),
    .rsp_misaligned(a32_mis), .rsp_timeout(a32_tmo));

  mem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(0)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(a64_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_address(a64_addr), .mem_read(a64_read), .mem_write(a64_write),
    .mem_wmask(a64_wmask), .mem_wdata(a64_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp & sel),
    .rsp_valid(a64_valid), .rsp_rdata(a64_rdata),
    .rsp_misaligned(a64_mis), .rsp_timeout(a64_tmo));

  logic        o_ready, o_read, o_write, o_valid, o_mis, o_tmo;
  logic [63:0] o_addr, o_wdata, o_rdata;
  logic [7:0]  o_wmask;
  assign o_ready = sel ? a64_ready : a32_ready;
  assign o_read  = sel ? a64_read  : a32_read;
  assign o_write = sel ? a64_write : a32_write;
  assign o_valid = sel ? a64_valid : a32_valid;
  assign o_mis   = sel ? a64_mis   : a32_mis;
  assign o_tmo   = sel ? a64_tmo   : a32_tmo;
  assign o_addr  = sel ? a64_addr  : {32'd0, a32_addr};
  assign o_wdata = sel ? a64_wdata : {32'd0, a32_wdata};
  assign o_rdata = sel ? a64_rdata : {32'd0, a32_rdata};
  assign o_wmask = sel ? a64_wmask : {4'd0, a32_wmask};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: pick the addressed bytes, then extend to the access width
  function automatic logic [63:0] ref_load(logic [63:0] rd, int off, int nb, bit uns, int xl);
    logic [63:0] v, m;
    if (xl == 32) rd = rd & 64'hFFFF_FFFF;
    v = rd >> (8 * off);
    m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One access; must be entered at a negedge with the selected unit idle.
  // delay = strobe cycle in which mem_resp is raised; 0 = never raise it.
  task automatic txn(input bit s, input bit we, input logic [1:0] size, input bit uns,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rdata, input int delay, output logic [63:0] rres);
    int xl, nbl, off, nb, exp_s, exp_c, scnt, gc;
    bit bad, tmo;
    logic [63:0] xm, e_rd;
    xl    = s ? 64 : 32;
    nbl   = xl / 8;
    xm    = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    off   = int'(addr % 64'(nbl));
    nb    = 1 << size;
    bad   = ((addr % 64'(nb)) != 0) || (size == 2'd3 && xl == 32);
    tmo   = !bad && delay == 0;
    exp_s = bad ? 0 : (tmo ? 8 : delay);
    exp_c = exp_s + 1;
    e_rd  = (bad || we || tmo) ? 64'd0 : ref_load(rdata, off, nb, uns, xl);
    sel = s;
    chk("ready_before", {63'd0, o_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    scnt = 0; gc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_resp  = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (o_valid) begin gc = c; break; end
      if (o_read | o_write) scnt++;
      chk("strobe_kind", {62'd0, o_read, o_write}, we ? 64'd1 : 64'd2);
      chk("mem_address", o_addr, (addr & xm) & ~64'(nbl - 1));
      if (we) begin
        chk("mem_wmask", {56'd0, o_wmask}, ((64'd1 << nb) - 64'd1) << off);
        chk("mem_wdata", o_wdata, ((wdata & xm) << (8 * off)) & xm);
      end
      if (scnt == delay) begin mem_resp = 1'b1; mem_rdata = rdata; end
    end
    chk("rsp_cycle", 64'(gc), 64'(exp_c));
    chk("strobe_cycles", 64'(scnt), 64'(exp_s));
    chk("strobe_at_rsp", {62'd0, o_read, o_write}, 64'd0);
    chk("ready_at_rsp", {63'd0, o_ready}, 64'd0);
    chk("rsp_rdata", o_rdata, e_rd);
    chk("rsp_misaligned", {63'd0, o_mis}, {63'd0, bad});
    chk("rsp_timeout", {63'd0, o_tmo}, {63'd0, tmo});
    rres = o_rdata;
    @(negedge clk);
    chk("pulse_width", {63'd0, o_valid}, 64'd0);
    chk("ready_after", {63'd0, o_ready}, 64'd1);
    chk("clear_after", {o_wmask, o_mis, o_tmo}, 64'd0);
    chk("rdata_after", o_rdata, 64'd0);
  endtask

  logic [63:0] r;
  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #0;
      chk("reset_ready", {63'd0, o_ready}, 64'd1);
      chk("reset_outs", {o_read, o_write, o_valid, o_mis, o_tmo, o_wmask}, 64'd0);
      chk("reset_buses", o_addr | o_wdata | o_rdata, 64'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // lb, lhu, lh
    txn(0, 0, 2'd0, 0, 64'h4000_0003, 0, 64'h80FF_1234, 2, r);
    chk("lb_value", r, 64'hFFFF_FF80);
    txn(0, 0, 2'd1, 1, 64'h4000_0002, 0, 64'hBEEF_1234, 1, r);
    chk("lhu_value", r, 64'h0000_BEEF);
    txn(0, 0, 2'd1, 0, 64'h4000_0002, 0, 64'h8001_5A5A, 3, r);
    chk("lh_value", r, 64'hFFFF_8001);
    // sh
    txn(0, 1, 2'd1, 0, 64'h4000_0006, 64'h1234_ABCD, 0, 3, r);
    // misaligned lw, illegal double on 32
    txn(0, 0, 2'd2, 0, 64'h4000_0002, 0, 0, 1, r);
    txn(0, 1, 2'd3, 0, 64'h4000_0000, 64'h55, 0, 1, r);
    // timeout then back-to-back sw; resp in the timeout cycle wins
    txn(0, 0, 2'd2, 0, 64'h4000_0000, 0, 0, 0, r);
    txn(0, 1, 2'd2, 0, 64'h4000_0010, 64'hCAFE_F00D, 0, 2, r);
    txn(0, 0, 2'd2, 0, 64'h4000_0010, 0, 64'h1357_9BDF, 8, r);
    chk("resp_beats_timeout", r, 64'h1357_9BDF);

    // mem_resp while idle is ignored
    mem_resp = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_resp_ignored", {63'd0, o_valid}, 64'd0);
    end
    mem_resp = 1'b0;

    // 64-bit: ld, lwu, misaligned ld, sd
    txn(1, 0, 2'd3, 0, 64'h8, 0, 64'h0123_4567_89AB_CDEF, 2, r);
    chk("ld_value", r, 64'h0123_4567_89AB_CDEF);
    txn(1, 0, 2'd2, 1, 64'hC, 0, 64'hF000_0000_0000_0000, 1, r);
    chk("lwu_value", r, 64'h0000_0000_F000_0000);
    txn(1, 0, 2'd3, 0, 64'h4, 0, 0, 1, r);
    txn(1, 1, 2'd1, 0, 64'h1E, 64'hBEEF, 0, 2, r);

    // randomized accesses on both widths
    for (int n = 0; n < 60; n++) begin
      logic [63:0] ra;
      logic [1:0]  rs;
      rs = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) ra = ra & ~64'(7);
      ra = ra | 64'($urandom_range(0, 7) & ((1 << rs) - 1));
      if ($urandom_range(0, 7) == 0) ra = ra | 64'd1;
      txn(n[0], $urandom_range(0, 1) == 1, rs, $urandom_range(0, 1) == 1, ra,
          {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 8), r);
    end

    // reset in the middle of an access
    sel = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_reset_strobe", {63'd0, o_read}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_strobe", {62'd0, o_read, o_write}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {62'd0, o_valid, o_read}, 64'd0);
    end
    txn(1, 0, 2'd0, 0, 64'h21, 0, 64'h0000_0000_0000_7F00, 1, r);
    chk("post_rst_lb", r, 64'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store access unit between the multicycle RV32I/RV64I control/datapath and the word-addressed memory port.
- Accepts one byte/half/word(/double) access request at a time and performs the `mem_resp` handshake.
- Generates the aligned address, write mask and lane-shifted write data for stores.
- For loads, returns lane-extracted, sign- or zero-extended read data, replacing fixed-width word-only load/store handling.
- Detects misaligned or illegal accesses and bounds memory wait time with an optional timeout.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT_CYCLES, 0, maximum cycles to wait for `mem_resp`; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  access request present
- req_ready  output  1  unit idle and able to accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word, 3 double (legal only when XLEN=64)
- req_unsigned  input  1  zero-extend load result (lbu/lhu/lwu)
- req_addr  input  XLEN  byte address
- req_wdata  input  XLEN  store data, right-justified
- mem_address  output  XLEN  aligned address (low log2(XLEN/8) bits zero)
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_wmask  output  XLEN/8  byte-lane write enables
- mem_wdata  output  XLEN  lane-shifted store data
- mem_rdata  input  XLEN  memory read data, valid with mem_resp
- mem_resp  input  1  memory access complete
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  XLEN  extended load result; 0 for stores and errors
- rsp_misaligned  output  1  access rejected: misaligned or illegal size
- rsp_timeout  output  1  access aborted by timeout

Behaviour:
- Reset values: all outputs registered. On reset: state IDLE, req_ready=1, every other output 0, wait counter 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready. Latch req_we, req_size, req_unsigned and offset = req_addr[log2(XLEN/8)-1:0].
  - Error path: if (addr mod (1<<size)) != 0, or size=3 with XLEN=32, go to DONE with rsp_misaligned=1. No memory strobe is ever raised.
  - Normal path: go to ACCESS. Set mem_address = req_addr with low offset bits cleared.
  - Stores: mem_wmask = ((1<<(1<<size))-1) << offset; mem_wdata = req_wdata << (8*offset).
- ACCESS:
  - mem_read (load) or mem_write (store) is held high every cycle until exit.
  - Address, mask and wdata are held stable for the whole access.
  - Wait counter increments each ACCESS cycle.
  - On mem_resp=1: drop the strobe and go to DONE.
    - Loads: rsp_rdata = (mem_rdata >> 8*offset) truncated to 8<<size bits, then sign-extended (req_unsigned=0) or zero-extended to XLEN.
    - Stores: rsp_rdata = 0.
  - Timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with no mem_resp, drop the strobe and go to DONE with rsp_timeout=1 and rsp_rdata=0.
  - If mem_resp and timeout occur in the same cycle, mem_resp wins.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in ACCESS and DONE.
- Latency:
  - Request accepted at edge 0; strobe visible cycle 1.
  - mem_resp sampled at cycle k gives rsp_valid at cycle k+1.
  - Misaligned/illegal request gives rsp_valid at cycle 1.
- Error flags, rsp_rdata, mem_wmask and mem_wdata clear to 0 when returning to IDLE.
- mem_resp while in IDLE or DONE is ignored.
- req_valid while not ready is ignored; the requester must hold it.
- Reset mid-access: the next edge with rst=1 forces IDLE and drops strobes. No rsp_valid is produced for the aborted access.
- Counter width: $clog2(TIMEOUT_CYCLES+1) (minimum 1). Counter clears on entering ACCESS.

Test Plan:
1. XLEN=32 lb: addr 0x40000003, mem_rdata 0x80FF1234, mem_resp after 2 cycles -> mem_address 0x40000000; mem_read high 2 cycles; rsp_rdata 0xFFFFFF80; rsp_valid one cycle after mem_resp.
2. lhu: addr 0x40000002, mem_rdata 0xBEEF1234 -> rsp_rdata 0x0000BEEF. Same request as lh with mem_rdata 0x8001xxxx -> 0xFFFF8001.
3. sh: addr 0x40000006, wdata 0x1234ABCD -> mem_address 0x40000004, mem_wmask 4'b1100, mem_wdata 0xABCD0000, mem_write held until mem_resp, rsp_rdata 0.
4. lw at 0x40000002, and size=3 with XLEN=32 -> rsp_valid at cycle 1, rsp_misaligned=1, mem_read/mem_write never asserted.
5. TIMEOUT_CYCLES=8, mem_resp never asserted -> mem_read high exactly 8 cycles, then rsp_valid with rsp_timeout=1, rsp_rdata 0. Then a back-to-back sw completes normally.
6. XLEN=64 ld at 0x8, and lwu at 0xC with mem_rdata 0xF0000000_00000000 -> 64-bit pass-through for ld; 0x00000000F0000000 for lwu. Separately, rst asserted mid-ACCESS -> next cycle state IDLE, strobes 0, req_ready 1, no rsp_valid.
